// File: rtl/sync_upcount_ctrl_if.sv
// Control/status bundle for sync_upcount_ctrl: the master drives the requests,
// the counter (slave) returns count and status flags.
interface sync_upcount_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             start;
   logic             mode;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] counter;
   logic             tc;
   logic             wrap;
   logic             busy;
   logic             done;

   modport master (
      output en, start, mode, load, load_val,
      input  counter, tc, wrap, busy, done
   );

   modport slave (
      input  en, start, mode, load, load_val,
      output counter, tc, wrap, busy, done
   );
endinterface

// File: rtl/sync_upcount_ctrl.sv
// Modulo up-counter 0..MAX with start/stop control, free-run or one-shot mode,
// synchronous clamped load, terminal-count flag and registered wrap pulse.
module sync_upcount_ctrl #(
   parameter int WIDTH = 4,
   parameter int MAX   = 15
) (
   input  logic                clk,
   input  logic                reset,
   sync_upcount_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             mode_q,  mode_d;
   logic             wrap_q,  wrap_d;

   // Priority per edge: load > start > counting; wrap is a one-edge event.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
      state_d = state_q;
      count_d = count_q;
      mode_d  = mode_q;
      wrap_d  = 1'b0;
      if (bus.load) begin
         count_d = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
      end else if (bus.start) begin
         count_d = '0;
         mode_d  = bus.mode;
         state_d = RUN;
      end else if (state_q == RUN && bus.en) begin
         if (count_q < MAX_V) begin
            count_d = count_q + WIDTH'(1);
         end else if (!mode_q) begin
            count_d = '0;
            wrap_d  = 1'b1;
         end else begin
            state_d = DONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         mode_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         mode_q  <= mode_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.counter = count_q;
   assign bus.tc      = (count_q == MAX_V);
   assign bus.wrap    = wrap_q;
   assign bus.busy    = (state_q == RUN);
   assign bus.done    = (state_q == DONE);
endmodule
